// File: rtl/agc_gain_ctrl.sv
// Automatic gain control sequencer: turns windowed RMS results into PGA gain steps.
// Latency: rms_valid at edge t -> rms sampled at t+1 -> new gain, clip and gain_wr visible after t+2.
// Backpressure: none; a window arriving while one is pending merges, one arriving during a write is dropped.
//
// Ports:
//   clk_sample  in   1       sample clock, all logic on posedge
//   rst         in   1       asynchronous reset, active high
//   en          in   1       AGC enable; 0 freezes gain and returns to idle
//   rms         in   12      RMS magnitude, valid on the cycle after rms_valid
//   rms_valid   in   1       one-cycle pulse: an RMS window has finished
//   gain        out  GAIN_W  current gain code (registered)
//   gain_wr     out  1       one-cycle strobe while the new gain must be written to the PGA
//   settling    out  1       high while windows are being discarded after enable or a gain write
//   clip        out  1       one-cycle pulse on a clip decision
module agc_gain_ctrl #(
    parameter int GAIN_W      = 6,
    parameter int GAIN_INIT   = 32,
    parameter int GAIN_MAX    = 63,
    parameter int TH_HI       = 1400,
    parameter int TH_LO       = 700,
    parameter int CLIP_TH     = 2000,
    parameter int ATTACK_STEP = 4,
    parameter int DECAY_WIN   = 4,
    parameter int SETTLE_WIN  = 1
) (
    input  logic              clk_sample,
    input  logic              rst,
    input  logic              en,
    input  logic [11:0]       rms,
    input  logic              rms_valid,
    output logic [GAIN_W-1:0] gain,
    output logic              gain_wr,
    output logic              settling,
    output logic              clip
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_TRACK  = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    localparam int CNT_W = 8;
    // Two extra bits: one for the sign of an undershoot, one for the +1 overshoot.
    localparam int NXT_W = GAIN_W + 2;

    localparam logic signed [NXT_W-1:0] C_ATK1 = NXT_W'(ATTACK_STEP);
    localparam logic signed [NXT_W-1:0] C_ATK2 = NXT_W'(2 * ATTACK_STEP);
    localparam logic signed [NXT_W-1:0] C_ONE  = NXT_W'(1);
    localparam logic signed [NXT_W-1:0] C_GMAX = NXT_W'(GAIN_MAX);

    localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_WIN);
    localparam logic [CNT_W-1:0] C_DECAY  = CNT_W'(DECAY_WIN);
    localparam logic             C_NO_SETTLE = (SETTLE_WIN == 0);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_settle_cnt;
    logic [CNT_W-1:0]  r_low_cnt;
    logic              r_pend;
    logic              r_cap;
    logic [11:0]       r_rms;
    logic [GAIN_W-1:0] r_gain;
    logic              r_clip;

    logic signed [NXT_W-1:0] w_gain_s;
    logic signed [NXT_W-1:0] w_next_raw;
    logic [GAIN_W-1:0]       w_next;
    logic [CNT_W-1:0]        w_low_inc;
    logic [CNT_W-1:0]        w_low_next;
    logic                    w_clip_hit;

    assign gain     = r_gain;
    assign clip     = r_clip;
    assign gain_wr  = (r_state == S_UPDATE);
    assign settling = (r_state == S_SETTLE);

    // Capture: the estimator moves rms on the negedge after its valid pulse,
    // so the value is taken one cycle after the pulse. r_cap marks the cycle
    // in which the FSM consumes the captured value.
    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_cap  <= 1'b0;
            r_rms  <= '0;
        end else if (!en) begin
            r_pend <= 1'b0;
            r_cap  <= 1'b0;
        end else begin
            r_cap <= r_pend;
            if (r_pend) begin
                // A pulse coinciding with the capture is absorbed by it.
                r_rms  <= rms;
                r_pend <= 1'b0;
            end else if (rms_valid && (r_state != S_UPDATE)) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Gain decision for one tracked window, in priority order clip / attack / decay / hold.
    always_comb begin
        w_gain_s   = $signed({2'b00, r_gain});
        w_next_raw = w_gain_s;
        w_clip_hit = 1'b0;
        w_low_inc  = r_low_cnt + CNT_W'(1);
        w_low_next = '0;
        if (r_rms >= 12'(CLIP_TH)) begin
            w_clip_hit = 1'b1;
            w_next_raw = w_gain_s - C_ATK2;
        end else if (r_rms > 12'(TH_HI)) begin
            w_next_raw = w_gain_s - C_ATK1;
        end else if (r_rms < 12'(TH_LO)) begin
            if (w_low_inc >= C_DECAY) begin
                w_next_raw = w_gain_s + C_ONE;
            end else begin
                w_low_next = w_low_inc;
            end
        end

        if (w_next_raw[NXT_W-1]) begin
            w_next = '0;
        end else if (w_next_raw > C_GMAX) begin
            w_next = GAIN_W'(GAIN_MAX);
        end else begin
            w_next = w_next_raw[GAIN_W-1:0];
        end
    end

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gain       <= GAIN_W'(GAIN_INIT);
            r_settle_cnt <= '0;
            r_low_cnt    <= '0;
            r_clip       <= 1'b0;
        end else begin
            r_clip <= 1'b0;
            if (!en) begin
                r_state      <= S_IDLE;
                r_settle_cnt <= '0;
                r_low_cnt    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (C_NO_SETTLE) begin
                            r_state <= S_TRACK;
                        end else begin
                            r_state      <= S_SETTLE;
                            r_settle_cnt <= C_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_cap) begin
                            if (r_settle_cnt <= CNT_W'(1)) begin
                                r_state      <= S_TRACK;
                                r_settle_cnt <= '0;
                            end else begin
                                r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                            end
                        end
                    end
                    S_TRACK: begin
                        if (r_cap) begin
                            r_low_cnt <= w_low_next;
                            r_clip    <= w_clip_hit;
                            // A clamp back onto the current code is not a change.
                            if (w_next != r_gain) begin
                                r_gain  <= w_next;
                                r_state <= S_UPDATE;
                            end
                        end
                    end
                    S_UPDATE: begin
                        if (C_NO_SETTLE) begin
                            r_state <= S_TRACK;
                        end else begin
                            r_state      <= S_SETTLE;
                            r_settle_cnt <= C_SETTLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Self-checking bench for agc_gain_ctrl: window-level reference model plus per-cycle output compare.
// Latency: expectations change two edges after each window's valid pulse.
// Backpressure: not applicable; windows are spaced so each one completes before the next.
module tb_agc_gain_ctrl;

    localparam int GAIN_INIT   = 32;
    localparam int GAIN_MAX    = 63;
    localparam int TH_HI       = 1400;
    localparam int TH_LO       = 700;
    localparam int CLIP_TH     = 2000;
    localparam int ATTACK_STEP = 4;
    localparam int DECAY_WIN   = 4;
    localparam int SETTLE_WIN  = 1;

    logic        clk_sample = 1'b0;
    logic        rst        = 1'b1;
    logic        en         = 1'b0;
    logic [11:0] rms        = '0;
    logic        rms_valid  = 1'b0;
    logic [5:0]  gain;
    logic        gain_wr;
    logic        settling;
    logic        clip;

    agc_gain_ctrl dut (
        .clk_sample (clk_sample),
        .rst        (rst),
        .en         (en),
        .rms        (rms),
        .rms_valid  (rms_valid),
        .gain       (gain),
        .gain_wr    (gain_wr),
        .settling   (settling),
        .clip       (clip)
    );

    always #5 clk_sample = ~clk_sample;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_wr  = 0;
    int   n_clip = 0;
    logic chk_on = 1'b0;

    // Expected outputs, valid at every negedge.
    int   exp_gain     = GAIN_INIT;
    logic exp_wr       = 1'b0;
    logic exp_clip     = 1'b0;
    logic exp_settling = 1'b0;

    // Window-level model state.
    int   m_gain    = GAIN_INIT;
    int   m_low     = 0;
    int   m_discard = 0;
    logic m_en      = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk_sample) begin
        if (chk_on) begin
            chk("gain", int'(gain), exp_gain);
            chk("gain_wr", int'(gain_wr), int'(exp_wr));
            chk("clip", int'(clip), int'(exp_clip));
            chk("settling", int'(settling), int'(exp_settling));
            if (gain_wr) n_wr++;
            if (clip) n_clip++;
        end
    end

    task automatic tick();
        @(posedge clk_sample);
        #1;
    endtask

    task automatic model_reset();
        exp_gain     = GAIN_INIT;
        exp_wr       = 1'b0;
        exp_clip     = 1'b0;
        exp_settling = 1'b0;
        m_gain       = GAIN_INIT;
        m_low        = 0;
        m_discard    = 0;
        m_en         = 1'b0;
    endtask

    // Outcome of one RMS window as seen by the AGC.
    task automatic decide(input int r, output logic wrote);
        int  nxt;
        wrote = 1'b0;
        if (!m_en) return;
        if (m_discard > 0) begin
            m_discard--;
            if (m_discard == 0) exp_settling = 1'b0;
            return;
        end
        nxt = m_gain;
        if (r >= CLIP_TH) begin
            nxt = m_gain - 2 * ATTACK_STEP;
            exp_clip = 1'b1;
            m_low = 0;
        end else if (r > TH_HI) begin
            nxt = m_gain - ATTACK_STEP;
            m_low = 0;
        end else if (r < TH_LO) begin
            m_low++;
            if (m_low == DECAY_WIN) begin
                nxt = m_gain + 1;
                m_low = 0;
            end
        end else begin
            m_low = 0;
        end
        if (nxt < 0) nxt = 0;
        if (nxt > GAIN_MAX) nxt = GAIN_MAX;
        if (nxt != m_gain) begin
            m_gain    = nxt;
            exp_gain  = nxt;
            exp_wr    = 1'b1;
            wrote     = 1'b1;
            m_discard = SETTLE_WIN;
        end
    endtask

    // One RMS window: valid pulse with junk on rms, the real value only on the capture cycle.
    task automatic window(input int r);
        logic wrote;
        rms_valid = 1'b1;
        rms = 12'($urandom_range(0, 4095));
        tick();
        rms_valid = 1'b0;
        rms = 12'(r);
        tick();
        rms = 12'($urandom_range(0, 4095));
        tick();
        decide(r, wrote);
        tick();
        exp_wr   = 1'b0;
        exp_clip = 1'b0;
        if (wrote && SETTLE_WIN > 0) exp_settling = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic set_en(input logic v);
        en = v;
        tick();
        if (v && !m_en) begin
            m_discard    = SETTLE_WIN;
            exp_settling = (SETTLE_WIN > 0);
        end else if (!v) begin
            m_discard    = 0;
            m_low        = 0;
            exp_settling = 1'b0;
        end
        m_en = v;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic int rand_rms();
        int b;
        b = $urandom_range(0, 9);
        if (b < 5)       return $urandom_range(0, TH_LO - 1);
        else if (b < 7)  return $urandom_range(TH_LO, TH_HI);
        else if (b < 9)  return $urandom_range(TH_HI + 1, CLIP_TH - 1);
        else             return $urandom_range(CLIP_TH, 4095);
    endfunction

    initial begin
        int w0;
        int c0;

        // Reset state
        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_gain_lit", int'(gain), 32);
        chk("rst_wr_lit", int'(gain_wr), 0);
        chk("rst_settling_lit", int'(settling), 0);
        rst = 1'b0;
        tick();

        // 1: first window discarded, in-band windows never change gain
        set_en(1'b1);
        chk("t1_settling_lit", int'(settling), 1);
        for (int i = 0; i < 4; i++) window(1000);
        chk("t1_gain_lit", int'(gain), 32);
        chk("t1_wr_cnt_lit", n_wr, 0);

        // 2: attack by one step, next window ignored
        w0 = n_wr;
        window(1500);
        chk("t2_gain_lit", int'(gain), 28);
        chk("t2_wr_cnt_lit", n_wr - w0, 1);
        chk("t2_settling_lit", int'(settling), 1);
        window(1500);
        chk("t2_discard_gain_lit", int'(gain), 28);

        // 3: clip steps, clamp to 0, clip at 0 without write
        do_reset();
        set_en(1'b1);
        window(1000);
        c0 = n_clip;
        window(2047);
        chk("t3_clip_gain_lit", int'(gain), 24);
        chk("t3_clip_cnt_lit", n_clip - c0, 1);
        for (int i = 0; i < 5; i++) begin
            window(1000);
            window(1500);
        end
        chk("t3_gain4_lit", int'(gain), 4);
        window(1000);
        for (int i = 0; i < 4; i++) window(500);
        chk("t3_gain5_lit", int'(gain), 5);
        window(1000);
        window(2047);
        chk("t3_clamp0_lit", int'(gain), 0);
        window(1000);
        w0 = n_wr;
        c0 = n_clip;
        window(2047);
        chk("t3_at0_wr_lit", n_wr - w0, 0);
        chk("t3_at0_clip_lit", n_clip - c0, 1);

        // 4: decay needs consecutive lows; no write at the top code
        do_reset();
        set_en(1'b1);
        window(1000);
        for (int i = 0; i < 3; i++) window(500);
        window(1000);
        for (int i = 0; i < 3; i++) window(500);
        chk("t4_hold_lit", int'(gain), 32);
        window(500);
        chk("t4_decay_lit", int'(gain), 33);
        for (int i = 0; i < 40 && m_gain < GAIN_MAX; i++) begin
            for (int j = 0; j < 5; j++) window(500);
        end
        chk("t4_top_lit", int'(gain), 63);
        window(500);
        w0 = n_wr;
        for (int i = 0; i < 4; i++) window(500);
        chk("t4_top_wr_lit", n_wr - w0, 0);

        // 5: disable mid-settle freezes gain; re-enable discards one window
        do_reset();
        set_en(1'b1);
        window(1000);
        window(1500);
        set_en(1'b0);
        w0 = n_wr;
        for (int i = 0; i < 3; i++) window(2047);
        chk("t5_frozen_lit", int'(gain), 28);
        chk("t5_no_wr_lit", n_wr - w0, 0);
        set_en(1'b1);
        window(2047);
        chk("t5_discard_lit", int'(gain), 28);
        window(2047);
        chk("t5_act_lit", int'(gain), 20);

        // 6: reset between capture and decision aborts the write
        window(1000);
        w0 = n_wr;
        rms_valid = 1'b1;
        rms = 12'($urandom_range(0, 4095));
        tick();
        rms_valid = 1'b0;
        rms = 12'd1500;
        tick();
        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("t6_gain_lit", int'(gain), 32);
        chk("t6_wr_lit", n_wr - w0, 0);
        window(2047);
        chk("t6_idle_lit", int'(gain), 32);

        // Randomised windows, enables and resets against the model
        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 99);
            if (k < 2) do_reset();
            else if (k < 6) set_en(!m_en);
            if (!m_en && $urandom_range(0, 2) != 0) set_en(1'b1);
            window(rand_rms());
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
